// File: rtl/sync_fifo_ctl.sv
// sync_fifo_ctl: single-clock FIFO with almost-full threshold, selectable registered/FWFT read, flush and sticky errors
module sync_fifo_ctl #(
  parameter int DATA_W = 74,
  parameter int ADDR_W = 4,
  parameter int FWFT   = 0
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              flush,
  input  logic              clr_err,
  input  logic [ADDR_W:0]   k_lim,
  input  logic              wrreq,
  input  logic [DATA_W-1:0] wrdata,
  output logic              wrfull,
  output logic              almfull,
  input  logic              rdreq,
  output logic [DATA_W-1:0] rddata,
  output logic              rdempty,
  output logic [ADDR_W:0]   usedw,
  output logic              overflow,
  output logic              underflow
);
  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(2**ADDR_W);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] rd_q;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   nxt;
  logic              wr_ok, rd_ok, clr;
  always_comb begin
    clr   = srst | flush;
    wr_ok = wrreq & ~wrfull & ~clr;
    rd_ok = rdreq & ~rdempty & ~clr;
    nxt   = clr ? '0 : usedw + (ADDR_W+1)'(wr_ok) - (ADDR_W+1)'(rd_ok);
  end
  // flags come from the next count so they move in the same cycle as usedw
  always_ff @(posedge clk) begin
    usedw     <= nxt;
    wrfull    <= nxt == DEPTH;
    rdempty   <= nxt == '0;
    almfull   <= nxt >= k_lim;
    wr_ptr    <= clr ? '0 : wr_ptr + ADDR_W'(wr_ok);
    rd_ptr    <= clr ? '0 : rd_ptr + ADDR_W'(rd_ok);
    overflow  <= srst ? 1'b0 : (wrreq & wrfull & ~flush) | (overflow & ~clr_err);
    underflow <= srst ? 1'b0 : (rdreq & rdempty & ~flush) | (underflow & ~clr_err);
    rd_q      <= srst ? '0 : rd_ok ? mem[rd_ptr] : rd_q;
  end
  always_ff @(posedge clk)
    if (wr_ok) mem[wr_ptr] <= wrdata;
  assign rddata = (FWFT != 0) ? mem[rd_ptr] : rd_q;
endmodule

// File: tb/tb_sync_fifo_ctl.sv
// tb_sync_fifo_ctl: directed checks of sync_fifo_ctl in registered and FWFT read modes
module tb_sync_fifo_ctl;
  logic        clk = 0, srst = 0, flush = 0, clr_err = 0, wrreq = 0, rdreq = 0;
  logic [4:0]  k_lim = 5'd12;
  logic [73:0] wrdata = '0;
  logic        wrfull, almfull, rdempty, overflow, underflow;
  logic [73:0] rddata;
  logic [4:0]  usedw;
  logic        f_wrfull, f_almfull, f_rdempty, f_overflow, f_underflow;
  logic [73:0] f_rddata;
  logic [4:0]  f_usedw;
  int          n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  sync_fifo_ctl #(.DATA_W(74), .ADDR_W(4), .FWFT(0)) dut (
    .clk(clk), .srst(srst), .flush(flush), .clr_err(clr_err), .k_lim(k_lim),
    .wrreq(wrreq), .wrdata(wrdata), .wrfull(wrfull), .almfull(almfull),
    .rdreq(rdreq), .rddata(rddata), .rdempty(rdempty), .usedw(usedw),
    .overflow(overflow), .underflow(underflow));

  sync_fifo_ctl #(.DATA_W(74), .ADDR_W(4), .FWFT(1)) dut_f (
    .clk(clk), .srst(srst), .flush(flush), .clr_err(clr_err), .k_lim(k_lim),
    .wrreq(wrreq), .wrdata(wrdata), .wrfull(f_wrfull), .almfull(f_almfull),
    .rdreq(rdreq), .rddata(f_rddata), .rdempty(f_rdempty), .usedw(f_usedw),
    .overflow(f_overflow), .underflow(f_underflow));

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic w, input logic r, input logic [73:0] d);
    wrreq = w; rdreq = r; wrdata = d;
    @(posedge clk); #1;
    wrreq = 0; rdreq = 0;
  endtask

  initial begin
    // reset with both requests asserted
    srst = 1; wrreq = 1; rdreq = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_usedw", 128'(usedw), 128'(0));
    chk("rst_empty", 128'(rdempty), 128'(1));
    chk("rst_full", 128'(wrfull), 128'(0));
    chk("rst_alm", 128'(almfull), 128'(0));
    chk("rst_ovf", 128'(overflow), 128'(0));
    chk("rst_udf", 128'(underflow), 128'(0));
    chk("rst_rddata", 128'(rddata), 128'(0));
    srst = 0; wrreq = 0; rdreq = 0;
    // fill/drain three times to wrap the pointers
    for (int it = 0; it < 3; it++) begin
      for (int i = 0; i < 16; i++) begin
        cyc(1, 0, 74'(it*16 + i));
        if (i == 10) chk("t2_alm_lo", 128'(almfull), 128'(0));
        if (i == 11) chk("t2_alm_hi", 128'(almfull), 128'(1));
        if (i == 14) chk("t2_full_lo", 128'(wrfull), 128'(0));
        if (i == 15) chk("t2_full_hi", 128'(wrfull), 128'(1));
      end
      chk("t2_usedw_full", 128'(usedw), 128'(16));
      for (int i = 0; i < 16; i++) begin
        chk("t2_fwft_data", 128'(f_rddata), 128'(it*16 + i));
        cyc(0, 1, '0);
        chk("t2_rd_data", 128'(rddata), 128'(it*16 + i));
        if (i == 14) chk("t2_empty_lo", 128'(rdempty), 128'(0));
      end
      chk("t2_empty_hi", 128'(rdempty), 128'(1));
      chk("t2_usedw_empty", 128'(usedw), 128'(0));
    end
    // full collision: read accepted, write dropped
    for (int i = 0; i < 16; i++) cyc(1, 0, 74'(100 + i));
    cyc(1, 1, 74'(999));
    chk("t3_usedw", 128'(usedw), 128'(15));
    chk("t3_ovf", 128'(overflow), 128'(1));
    chk("t3_full", 128'(wrfull), 128'(0));
    chk("t3_udf", 128'(underflow), 128'(0));
    chk("t3_first", 128'(rddata), 128'(100));
    for (int i = 1; i < 16; i++) begin
      cyc(0, 1, '0);
      chk("t3_drain", 128'(rddata), 128'(100 + i));
    end
    chk("t3_empty", 128'(rdempty), 128'(1));
    // empty collision: write accepted, read flags underflow
    cyc(1, 1, 74'h55);
    chk("t4_usedw", 128'(usedw), 128'(1));
    chk("t4_udf", 128'(underflow), 128'(1));
    chk("t4_ovf_sticky", 128'(overflow), 128'(1));
    clr_err = 1;
    cyc(0, 0, '0);
    clr_err = 0;
    chk("t4_udf_clr", 128'(underflow), 128'(0));
    chk("t4_ovf_clr", 128'(overflow), 128'(0));
    cyc(0, 1, '0);
    chk("t4_data", 128'(rddata), 128'h55);
    clr_err = 1;
    cyc(0, 1, '0);
    clr_err = 0;
    chk("t4_set_prio", 128'(underflow), 128'(1));
    clr_err = 1;
    cyc(0, 0, '0);
    clr_err = 0;
    chk("t4_udf_clr2", 128'(underflow), 128'(0));
    // read mode timing
    cyc(1, 0, 74'hA5);
    chk("t5_fwft_empty", 128'(f_rdempty), 128'(0));
    chk("t5_fwft_data", 128'(f_rddata), 128'hA5);
    chk("t5_reg_hold", 128'(rddata), 128'h55);
    cyc(0, 1, '0);
    chk("t5_reg_data", 128'(rddata), 128'hA5);
    chk("t5_empty", 128'(rdempty), 128'(1));
    // flush mid-operation at usedw=9 with overflow set
    for (int i = 0; i < 16; i++) cyc(1, 0, 74'(200 + i));
    cyc(1, 0, 74'(999));
    for (int i = 0; i < 7; i++) cyc(0, 1, '0);
    chk("t6_usedw9", 128'(usedw), 128'(9));
    chk("t6_ovf_pre", 128'(overflow), 128'(1));
    flush = 1;
    cyc(1, 1, 74'(777));
    flush = 0;
    chk("t6_usedw", 128'(usedw), 128'(0));
    chk("t6_empty", 128'(rdempty), 128'(1));
    chk("t6_full", 128'(wrfull), 128'(0));
    chk("t6_alm", 128'(almfull), 128'(0));
    chk("t6_ovf", 128'(overflow), 128'(1));
    chk("t6_rd_hold", 128'(rddata), 128'(206));
    cyc(1, 0, 74'h321);
    cyc(0, 1, '0);
    chk("t6_first", 128'(rddata), 128'h321);
    flush = 1;
    cyc(1, 1, '0);
    flush = 0;
    chk("t6_flush_udf", 128'(underflow), 128'(0));
    chk("t6_flush_nowr", 128'(usedw), 128'(0));
    // threshold boundaries
    k_lim = 5'd0;
    cyc(0, 0, '0);
    chk("klim0_alm", 128'(almfull), 128'(1));
    k_lim = 5'd31;
    for (int i = 0; i < 16; i++) cyc(1, 0, '0);
    chk("klim_big_alm", 128'(almfull), 128'(0));
    k_lim = 5'd16;
    cyc(0, 0, '0);
    chk("klim16_alm", 128'(almfull), 128'(1));
    k_lim = 5'd0;
    srst = 1;
    cyc(0, 0, '0);
    srst = 0;
    chk("rst_alm_k0", 128'(almfull), 128'(1));
    chk("rst_usedw2", 128'(usedw), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
